// File: rtl/tpu_job_sched.sv
// tpu_job_sched: job scheduler in front of the tpu matrix-multiply core.
//
// Two requesters (0 = host, 1 = DMA) offer job descriptors. A round-robin
// arbiter pushes at most one per cycle into a small FIFO. Jobs are launched
// on the TPU one at a time, and each one is reported once it finishes.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i[1:0]     requester r offers a descriptor
//   req_ready_o[1:0]     descriptor of requester r accepted this cycle
//                        (combinational, depends on req_valid_i)
//   req{0,1}_desc_i      {m, k, n, base_a, base_b, base_p}, m in the MSBs
//   tpu_start_o          one-cycle start pulse to the TPU
//   tpu_*_o              descriptor of the running job, held until the next load
//   tpu_valid_i          TPU completion level; its rising edge ends a job
//   done_o               one-cycle completion pulse
//   done_id_o            requester index of the completed job
//   done_err_o           job rejected (zero dimension) or timed out
//   done_cycles_o        busy cycles of the completed job
//   busy_o               scheduler is not idle
//   fifo_level_o         descriptor FIFO occupancy
//
// state  | meaning
// IDLE   | waiting for a queued job; pops the FIFO head when one is present
// LAUNCH | start pulse to the TPU
// BUSY   | TPU running; counting cycles, watching for valid rising / timeout
// DONE   | completion pulse with id, error flag and cycle count
module tpu_job_sched #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0]                req_valid_i,
  output logic [1:0]                req_ready_o,
  input  logic [6*ADDR_WIDTH-1:0]   req0_desc_i,
  input  logic [6*ADDR_WIDTH-1:0]   req1_desc_i,
  output logic                      tpu_start_o,
  output logic [ADDR_WIDTH-1:0]     tpu_m_o,
  output logic [ADDR_WIDTH-1:0]     tpu_k_o,
  output logic [ADDR_WIDTH-1:0]     tpu_n_o,
  output logic [ADDR_WIDTH-1:0]     tpu_base_a_o,
  output logic [ADDR_WIDTH-1:0]     tpu_base_b_o,
  output logic [ADDR_WIDTH-1:0]     tpu_base_p_o,
  input  logic                      tpu_valid_i,
  output logic                      done_o,
  output logic                      done_id_o,
  output logic                      done_err_o,
  output logic [15:0]               done_cycles_o,
  output logic                      busy_o,
  output logic [$clog2(DEPTH):0]    fifo_level_o
);

  localparam int DW = 6 * ADDR_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_e;

  state_e state_q, state_d;

  // FIFO entry is {id, descriptor}
  logic [DW:0]     mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   count_q;
  logic            rr_q;
  logic            valid_prev_q;
  logic [15:0]     cnt_q;
  logic            cur_id_q;

  logic            empty, full, pop, push, push_id;
  logic [1:0]      ready;
  logic [DW-1:0]   push_desc;
  logic [DW:0]     head;
  logic            head_zero;
  logic            rise;
  logic [15:0]     cnt_inc;

  logic            load_desc, load_done, err_d, id_d;
  logic [15:0]     cycles_d;

  assign empty = (count_q == '0);
  assign full  = (count_q == LW'(DEPTH));
  assign pop   = (state_q == IDLE) && !empty;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  always_comb begin
    ready = 2'b00;
    if (!(full && !pop)) begin
      ready[0] = req_valid_i[0] && (!rr_q || !req_valid_i[1]);
      ready[1] = req_valid_i[1] && ( rr_q || !req_valid_i[0]);
    end
  end

  // Ready is combinational; force it low while reset is asserted.
  assign req_ready_o = rst_ni ? ready : 2'b00;
  assign push        = |ready;
  assign push_id     = ready[1];
  assign push_desc   = push_id ? req1_desc_i : req0_desc_i;

  assign head      = mem_q[rd_ptr_q];
  assign head_zero = (head[DW-1 -: ADDR_WIDTH] == '0) ||
                     (head[DW-1-ADDR_WIDTH -: ADDR_WIDTH] == '0) ||
                     (head[DW-1-2*ADDR_WIDTH -: ADDR_WIDTH] == '0);

  // A level already high when BUSY begins never counts as completion.
  assign rise    = tpu_valid_i && !valid_prev_q;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  assign fifo_level_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        rr_q     <= ~push_id;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {push_id, push_desc};
  end

  always_comb begin
    state_d   = state_q;
    load_desc = 1'b0;
    load_done = 1'b0;
    err_d     = 1'b0;
    id_d      = cur_id_q;
    cycles_d  = '0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          id_d = head[DW];
          if (head_zero) begin
            state_d   = DONE;
            load_done = 1'b1;
            err_d     = 1'b1;
          end else begin
            state_d   = LAUNCH;
            load_desc = 1'b1;
          end
        end
      end
      LAUNCH: state_d = BUSY;
      BUSY: begin
        if (rise) begin
          state_d   = DONE;
          load_done = 1'b1;
          cycles_d  = cnt_inc;
        end else if (cnt_inc >= TIMEOUT_C) begin
          state_d   = DONE;
          load_done = 1'b1;
          err_d     = 1'b1;
          cycles_d  = cnt_inc;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cur_id_q      <= 1'b0;
      cnt_q         <= '0;
      valid_prev_q  <= 1'b0;
      tpu_start_o   <= 1'b0;
      tpu_m_o       <= '0;
      tpu_k_o       <= '0;
      tpu_n_o       <= '0;
      tpu_base_a_o  <= '0;
      tpu_base_b_o  <= '0;
      tpu_base_p_o  <= '0;
      done_o        <= 1'b0;
      done_id_o     <= 1'b0;
      done_err_o    <= 1'b0;
      done_cycles_o <= '0;
      busy_o        <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_prev_q <= tpu_valid_i;
      tpu_start_o  <= (state_d == LAUNCH);
      done_o       <= load_done;
      busy_o       <= (state_d != IDLE);
      if (pop) begin
        cur_id_q <= head[DW];
        cnt_q    <= '0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_inc;
      end
      if (load_desc) begin
        tpu_m_o      <= head[DW-1              -: ADDR_WIDTH];
        tpu_k_o      <= head[DW-1-ADDR_WIDTH   -: ADDR_WIDTH];
        tpu_n_o      <= head[DW-1-2*ADDR_WIDTH -: ADDR_WIDTH];
        tpu_base_a_o <= head[DW-1-3*ADDR_WIDTH -: ADDR_WIDTH];
        tpu_base_b_o <= head[DW-1-4*ADDR_WIDTH -: ADDR_WIDTH];
        tpu_base_p_o <= head[DW-1-5*ADDR_WIDTH -: ADDR_WIDTH];
      end
      if (load_done) begin
        done_id_o     <= id_d;
        done_err_o    <= err_d;
        done_cycles_o <= cycles_d;
      end
    end
  end

endmodule

// File: doc/tpu_job_sched.md
# tpu_job_sched

Job scheduler in front of the `tpu` matrix-multiply core. It accepts matrix-multiply job descriptors from two requesters (host and DMA) through round-robin arbitration into a small descriptor FIFO. It launches jobs on the single TPU one at a time by driving its `start_i`, `m_i/k_i/n_i` and `base_addr*_i` inputs, then reports per-job completion, error and cycle count. It sits between the control fabric and `tpu`; the TPU buffer ports are not touched.

## Interface
- `ADDR_WIDTH`, 12: width of each descriptor field (`m`, `k`, `n`, three base addresses).
- `DEPTH`, 4: descriptor FIFO entries, power of two ≥ 2.
- `TIMEOUT`, 4096: maximum busy cycles per job before abort-as-error; must be less than 2^16.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_valid_i` in 2: requester r offers a descriptor.
- `req_ready_o` out 2: requester r's descriptor is accepted this cycle when valid is also high.
- `req0_desc_i`, `req1_desc_i` in 6*ADDR_WIDTH: packed {m, k, n, base_a, base_b, base_p}, with m in the MSBs.
- `tpu_start_o` out 1: one-cycle start pulse to `tpu.start_i`.
- `tpu_m_o`, `tpu_k_o`, `tpu_n_o`, `tpu_base_a_o`, `tpu_base_b_o`, `tpu_base_p_o` out ADDR_WIDTH each: held stable from launch until done.
- `tpu_valid_i` in 1: `tpu.valid_o`.
- `done_o` out 1: one-cycle job-completion pulse.
- `done_id_o` out 1: requester index of the completed job.
- `done_err_o` out 1: completed job was rejected or timed out.
- `done_cycles_o` out 16: busy cycles of the completed job.
- `busy_o` out 1: high whenever the state is not IDLE.
- `fifo_level_o` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Arbitration.** A pointer `rr` holds the requester with priority.
  - The pointer resets to 0.
  - `req_ready_o[r] = !full && req_valid_i[r] && (rr==r || !req_valid_i[1-r])`. This is combinational and depends on valid.
  - At most one requester is accepted per cycle.
  - On acceptance, `rr` becomes `1 - accepted_index`.
  - When FIFO is full, both readies are low and `rr` is unchanged.
- **FIFO.**
  - Each entry is {id, desc}.
  - Push and pop may occur in the same cycle, including when full: the pop frees the slot combinationally, so readiness uses `full && !pop`.
  - Pointers wrap modulo DEPTH.
  - `fifo_level_o` updates one cycle after push or pop.
- **FSM states:** IDLE, LAUNCH, BUSY, DONE.
  - IDLE → LAUNCH: FIFO is non-empty. Pop the entry and load the descriptor into the `tpu_*_o` registers, `cur_id`, and clear the cycle counter.
  - IDLE → DONE with err=1, without LAUNCH: FIFO is non-empty and the popped m, k or n is 0. `tpu_start_o` never pulses for this job.
  - LAUNCH → BUSY: `tpu_start_o` is 1 for exactly this cycle.
  - BUSY → DONE with err=0: rising edge of `tpu_valid_i` (previous value low, current high, sampled only in BUSY). A valid level left over from a prior job never completes a job.
  - BUSY → DONE with err=1: the counter reaches TIMEOUT.
  - The cycle counter increments every BUSY cycle and saturates at 0xFFFF.
  - DONE → IDLE: `done_o`=1 for this cycle, with `done_id_o`, `done_err_o` and `done_cycles_o` valid in the same cycle.
- **Output holding.**
  - `tpu_*_o` descriptor outputs hold their last values after DONE until the next load.
  - `done_id_o`, `done_err_o` and `done_cycles_o` hold until the next DONE.
- **Reset.** Asynchronous assertion at any point, including mid-job:
  - FIFO empties; state goes to IDLE; `rr`=0.
  - All outputs go to 0.
  - The interrupted job is dropped and never reported.

## Timing
- Outputs at reset: `req_ready_o`=0, `tpu_start_o`=0, all `tpu_*_o`=0, `done_o`=0, `done_id_o`=0, `done_err_o`=0, `done_cycles_o`=0, `busy_o`=0, `fifo_level_o`=0.
- Launch latency: with the FIFO empty and IDLE, a descriptor accepted at edge N gives `tpu_start_o` high in cycle N+2. Edge N+1 is the IDLE pop; cycle N+2 is LAUNCH.
- Back-to-back jobs: DONE→IDLE→LAUNCH gives a minimum of 2 cycles from `done_o` to the next `tpu_start_o`.
- `done_cycles_o` = number of BUSY cycles. If `tpu_valid_i` rises in the first BUSY cycle, the value is 1.
- All outputs are registered except `req_ready_o`.

## Test plan
1. **Single valid job.** After reset, req0 sends {m=10, k=10, n=10, base 0x000/0x100/0x200}. The TPU model raises valid 30 cycles after start.
   - Required: `tpu_start_o` is one cycle, exactly 2 cycles after acceptance; descriptor outputs equal the sent values.
   - Required: `done_o` with id=0, err=0, cycles=30.
2. **Arbitration fairness.** Both requesters hold valid continuously with distinct descriptors and DEPTH=4.
   - Required: accepts alternate 0, 1, 0, 1.
   - Required: readies go low once `fifo_level_o`=4.
   - Required: done ids alternate in acceptance order.
3. **Zero-dimension reject.** req1 sends n=0.
   - Required: no `tpu_start_o` pulse.
   - Required: `done_o` with id=1, err=1, cycles=0.
   - Required: the following queued job still launches normally.
4. **Stale valid and timeout.**
   - With `tpu_valid_i` held high from before launch and never toggling, the job must not complete on the stale level. It completes at timeout with err=1 and cycles=TIMEOUT (use TIMEOUT=16).
5. **Full FIFO with simultaneous pop.** FIFO is full in IDLE while req0 is valid.
   - Required: ready is asserted in the pop cycle.
   - Required: the level stays 4, and entries are not lost or reordered.
6. **Reset mid-job.** Pulse `rst_ni` low asynchronously (off-edge) in BUSY with 2 jobs queued.
   - Required: all outputs are 0 immediately, no `done_o` follows, and the level is 0.
   - Required: a new job after release runs normally with id and `rr` starting from 0.
